instr_prefetch: RTL and testbench

- Instruction prefetch stage that sits directly upstream of the single-cycle CPU core.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel with variable response latency.
- Buffers returned {pc, instr} pairs in a small FIFO and delivers them to the core over a valid/ready interface.
- Handles redirects (taken branch, JAL, JALR) from the core by flushing the FIFO and squashing in-flight memory responses.

---
 rtl/instr_prefetch_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/instr_prefetch.sv | 121 ++++++++++++
 tb/tb_instr_prefetch.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_pkg.sv
// Shared definitions for the instruction prefetch stage: datapath width,
// default reset pc, the buffered fetch entry and the prefetch mode.
package instr_prefetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    // One buffered fetch result as seen by the core.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // FETCH: responses are live. DRAIN: responses still belong to a
    // pre-redirect stream and are discarded.
    typedef enum logic {
        MODE_FETCH = 1'b0,
        MODE_DRAIN = 1'b1
    } prefetch_mode_e;

    // Force an address onto a 4-byte boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push, pop, flush and an occupancy count.
// The head is visible combinationally; an empty FIFO presents all zeros.
// A push into an empty FIFO becomes visible on the following cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign push_ok = push && (count != CW'(DEPTH)) && !flush;
    assign pop_ok  = pop && !empty && !flush;

    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; occupancy decides validity and
        // the empty mask keeps stale contents off the output.
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: issues sequential word fetches under a credit
// limit, buffers in-order responses with their pc, and delivers them to the
// core. A redirect flushes the buffer and drains stale in-flight responses.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int OW  = $clog2(MAX_OUTST + 1);

    localparam logic [OW-1:0]  MAX_OUTST_C = OW'(MAX_OUTST);
    localparam logic [CW1-1:0] DEPTH_C     = CW1'(DEPTH);

    logic [XLEN-1:0] fetch_pc,    fetch_pc_n;
    logic [XLEN-1:0] resp_pc,     resp_pc_n;
    logic [OW-1:0]   outstanding, outstanding_n;
    logic [OW-1:0]   drop_cnt,    drop_cnt_n;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic [CW1-1:0]  credit_used;
    logic            req_fire;
    logic            rsp_accept;
    logic [XLEN-1:0] target_pc;
    prefetch_mode_e  mode;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign mode      = (drop_cnt != '0) ? MODE_DRAIN : MODE_FETCH;
    assign target_pc = word_align(redirect_pc);

    // Buffered entries plus in-flight requests may never exceed the FIFO size,
    // so every response that is accepted always has a free slot.
    assign credit_used   = {1'b0, fifo_count} + CW1'(outstanding);
    assign mem_req_valid = !reset && !redirect_valid &&
                           (outstanding < MAX_OUTST_C) && (credit_used < DEPTH_C);
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // A response arriving during a redirect cycle is stale and never pushed.
    assign rsp_accept = mem_rsp_valid && (mode == MODE_FETCH) && !redirect_valid;

    assign push_entry = '{pc: resp_pc, instr: mem_rsp_data};

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_accept),
        .push_data (push_entry),
        .pop       (out_ready),
        .flush     (redirect_valid),
        .pop_data  (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_pc    = head_entry.pc;
    assign out_instr = head_entry.instr;

    // Next-state for the fetch/response pointers and the in-flight counters.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        fetch_pc_n    = fetch_pc;
        resp_pc_n     = resp_pc;
        outstanding_n = outstanding;
        drop_cnt_n    = drop_cnt;

        if (req_fire)      outstanding_n = outstanding_n + OW'(1);
        if (mem_rsp_valid) outstanding_n = outstanding_n - OW'(1);

        if (redirect_valid) begin
            fetch_pc_n = target_pc;
            resp_pc_n  = target_pc;
            drop_cnt_n = outstanding - OW'(mem_rsp_valid);
        end else begin
            if (req_fire)   fetch_pc_n = fetch_pc + XLEN'(4);
            if (rsp_accept) resp_pc_n  = resp_pc + XLEN'(4);
            if (mem_rsp_valid && (mode == MODE_DRAIN)) drop_cnt_n = drop_cnt - OW'(1);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= word_align(RESET_PC);
            resp_pc     <= word_align(RESET_PC);
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            fetch_pc    <= fetch_pc_n;
            resp_pc     <= resp_pc_n;
            outstanding <= outstanding_n;
            drop_cnt    <= drop_cnt_n;
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: an in-order memory model with configurable or
// random latency, a per-cycle monitor that compares every delivered
// instruction against the expected sequential pc stream, and directed tasks.
module tb_instr_prefetch;
    import instr_prefetch_pkg::*;

    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    instr_prefetch #(
        .DEPTH     (DEPTH),
        .MAX_OUTST (MAX_OUTST),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Instruction word stored at a given address in the modelled memory.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- memory model: in-order, latency per request ----------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    cyc = 0;
    int    mem_lat = 1;
    bit    mem_rand_lat = 1'b0;
    bit    mem_rand_ready = 1'b0;

    initial begin : memory_model
        bit          hs;
        logic [31:0] a;
        int          lat;
        int          due;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            hs = mem_req_valid && mem_req_ready;
            a  = mem_req_addr;
            @(posedge clk);
            cyc++;
            if (reset) begin
                mq.delete();
            end else begin
                if (mem_rsp_valid && mq.size() > 0) mq.delete(0);
                if (hs) begin
                    lat = mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
                    due = cyc + lat - 1;
                    if (mq.size() > 0 && due < mq[mq.size()-1].due) due = mq[mq.size()-1].due;
                    mq.push_back('{addr: a, due: due});
                end
            end
            #1;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = instr_of(mq[0].addr);
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = $urandom;
            end
            mem_req_ready = mem_rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- per-cycle monitor and reference stream ---------------
    logic        s_out_valid, s_req_valid;
    logic [31:0] s_out_pc, s_out_instr, s_req_addr;
    bit          s_pop, s_hs;
    int          hs_total = 0;
    int          outst_m  = 0;
    logic [31:0] exp_pc   = RESET_PC;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_pc, prev_instr;
    int          pop_total = 0;

    // Advance one cycle: sample at the falling edge, check against the model,
    // then return just after the next rising edge for the caller to drive.
    task automatic step();
        @(negedge clk);
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_instr = out_instr;
        s_req_valid = mem_req_valid;
        s_req_addr  = mem_req_addr;
        s_pop       = out_valid && out_ready;
        s_hs        = mem_req_valid && mem_req_ready;
        if (reset) begin
            exp_pc    = RESET_PC;
            outst_m   = 0;
            prev_hold = 1'b0;
            s_pop     = 1'b0;
            s_hs      = 1'b0;
        end else begin
            if (prev_hold) begin
                vectors++;
                if (out_valid !== 1'b1 || out_pc !== prev_pc || out_instr !== prev_instr) begin
                    miscompares++;
                    $display("FAIL hold_stable: got valid=%b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                             out_valid, out_pc, out_instr, prev_pc, prev_instr);
                end
            end
            if (mem_req_valid) begin
                vectors++;
                if (mem_req_addr[1:0] !== 2'b00) begin
                    miscompares++;
                    $display("FAIL req_align: got addr=%h, expected low bits 00", mem_req_addr);
                end
            end
            if (s_pop) begin
                vectors++;
                pop_total++;
                if (out_pc !== exp_pc || out_instr !== instr_of(exp_pc)) begin
                    miscompares++;
                    $display("FAIL deliver: got pc=%h instr=%h, expected pc=%h instr=%h",
                             out_pc, out_instr, exp_pc, instr_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (s_hs) hs_total++;
            outst_m = outst_m + int'(s_hs) - int'(mem_rsp_valid);
            vectors++;
            if (outst_m < 0 || outst_m > MAX_OUTST) begin
                miscompares++;
                $display("FAIL outstanding: got %0d in flight, expected 0..%0d", outst_m, MAX_OUTST);
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
            prev_hold  = out_valid && !out_ready && !redirect_valid;
            prev_pc    = out_pc;
            prev_instr = out_instr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pop(output bit got);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            if (s_pop) got = 1'b1;
        end
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            if (s_req_valid) got = 1'b1;
        end
    endtask

    task automatic apply_reset(input int lat, input bit ready);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = ready;
        mem_lat        = lat;
        mem_rand_lat   = 1'b0;
        mem_rand_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
    endtask

    // ---------------- directed scenarios ----------------------------------
    task automatic test_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        step();
        step();
        vectors += 5;
        if (s_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b expected 0", s_req_valid); end
        if (s_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", s_out_valid); end
        if (s_req_addr !== RESET_PC) begin miscompares++; $display("FAIL reset_req_addr: got %h expected %h", s_req_addr, RESET_PC); end
        if (s_out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_out_pc: got %h expected 0", s_out_pc); end
        if (s_out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_out_instr: got %h expected 0", s_out_instr); end
    endtask

    task automatic test_latency();
        logic        ov[6];
        bit          pv[6];
        logic [31:0] pcs[6];
        apply_reset(1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            ov[k]  = s_out_valid;
            pv[k]  = s_pop;
            pcs[k] = s_out_pc;
            if (k == 0) begin
                vectors++;
                if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
                    miscompares++;
                    $display("FAIL first_req: got valid=%b addr=%h expected valid=1 addr=%h",
                             s_req_valid, s_req_addr, RESET_PC);
                end
            end
        end
        vectors += 3;
        if (ov[0] !== 1'b0) begin miscompares++; $display("FAIL latency_c0: got out_valid=%b expected 0", ov[0]); end
        if (ov[1] !== 1'b0) begin miscompares++; $display("FAIL latency_c1: got out_valid=%b expected 0", ov[1]); end
        if (ov[2] !== 1'b1) begin miscompares++; $display("FAIL latency_c2: got out_valid=%b expected 1", ov[2]); end
        for (int k = 2; k < 6; k++) begin
            vectors++;
            if (!pv[k] || pcs[k] !== RESET_PC + 32'(4 * (k - 2))) begin
                miscompares++;
                $display("FAIL throughput_c%0d: got pop=%0d pc=%h expected pop=1 pc=%h",
                         k, pv[k], pcs[k], RESET_PC + 32'(4 * (k - 2)));
            end
        end
    endtask

    task automatic test_backpressure();
        int hs0;
        apply_reset(1, 1'b0);
        hs0 = hs_total;
        for (int k = 0; k < 10; k++) step();
        vectors += 3;
        if (hs_total - hs0 != DEPTH) begin
            miscompares++;
            $display("FAIL bp_fetch_count: got %0d requests expected %0d", hs_total - hs0, DEPTH);
        end
        if (s_req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_req_valid: got %b expected 0", s_req_valid); end
        if (s_out_valid !== 1'b1 || s_out_pc !== RESET_PC) begin
            miscompares++;
            $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=%h", s_out_valid, s_out_pc, RESET_PC);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++;
            if (!s_pop || s_out_pc !== RESET_PC + 32'(4 * k)) begin
                miscompares++;
                $display("FAIL bp_drain_%0d: got pop=%0d pc=%h expected pop=1 pc=%h",
                         k, s_pop, s_out_pc, RESET_PC + 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect_drain();
        bit got;
        apply_reset(3, 1'b1);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            step();
            if (k >= 4 && outst_m == 2) got = 1'b1;
        end
        vectors++;
        if (!got) begin miscompares++; $display("FAIL drain_setup: got no 2-outstanding cycle within 40, expected one"); end
        do_redirect(32'h0000_0100);
        wait_pop(got);
        vectors++;
        if (!got || s_out_pc !== 32'h0000_0100) begin
            miscompares++;
            $display("FAIL drain_first: got delivered=%0d pc=%h expected delivered=1 pc=00000100", got, s_out_pc);
        end
    endtask

    task automatic test_misaligned();
        bit got;
        mem_lat = 1;
        do_redirect(32'h0000_0203);
        wait_req(got);
        vectors++;
        if (!got || s_req_addr !== 32'h0000_0200) begin
            miscompares++;
            $display("FAIL misalign_req: got req=%0d addr=%h expected req=1 addr=00000200", got, s_req_addr);
        end
        wait_pop(got);
        vectors++;
        if (!got || s_out_pc !== 32'h0000_0200) begin
            miscompares++;
            $display("FAIL misalign_out: got delivered=%0d pc=%h expected delivered=1 pc=00000200", got, s_out_pc);
        end
    endtask

    task automatic test_wrap();
        bit          got;
        logic [31:0] want;
        do_redirect(32'hFFFF_FFF8);
        want = 32'hFFFF_FFF8;
        for (int k = 0; k < 3; k++) begin
            wait_pop(got);
            vectors++;
            if (!got || s_out_pc !== want) begin
                miscompares++;
                $display("FAIL wrap_%0d: got delivered=%0d pc=%h expected delivered=1 pc=%h", k, got, s_out_pc, want);
            end
            want = want + 32'd4;
        end
    endtask

    task automatic test_reset_midop();
        bit got;
        apply_reset(3, 1'b0);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            step();
            if (s_out_valid && outst_m == 2) got = 1'b1;
        end
        vectors++;
        if (!got) begin miscompares++; $display("FAIL midop_setup: got no busy cycle within 40, expected one"); end
        reset = 1'b1;
        step();
        step();
        vectors += 3;
        if (s_out_valid !== 1'b0) begin miscompares++; $display("FAIL midop_out_valid: got %b expected 0", s_out_valid); end
        if (s_req_valid !== 1'b0) begin miscompares++; $display("FAIL midop_req_valid: got %b expected 0", s_req_valid); end
        if (s_req_addr !== RESET_PC) begin miscompares++; $display("FAIL midop_req_addr: got %h expected %h", s_req_addr, RESET_PC); end
        reset     = 1'b0;
        out_ready = 1'b1;
        wait_req(got);
        vectors++;
        if (!got || s_req_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL midop_restart_req: got req=%0d addr=%h expected req=1 addr=%h", got, s_req_addr, RESET_PC);
        end
        wait_pop(got);
        vectors++;
        if (!got || s_out_pc !== RESET_PC) begin
            miscompares++;
            $display("FAIL midop_restart_out: got delivered=%0d pc=%h expected delivered=1 pc=%h", got, s_out_pc, RESET_PC);
        end
    endtask

    task automatic test_random();
        int pops0;
        apply_reset(1, 1'b1);
        mem_rand_lat   = 1'b1;
        mem_rand_ready = 1'b1;
        pops0 = pop_total;
        for (int k = 0; k < 1500; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                             : $urandom;
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;
        vectors++;
        if (pop_total - pops0 < 200) begin
            miscompares++;
            $display("FAIL random_progress: got %0d deliveries expected at least 200", pop_total - pops0);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        test_reset();
        test_latency();
        test_backpressure();
        test_redirect_drain();
        test_misaligned();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
